chess_clock_game_ctrl: RTL and testbench
========================================

// Module: chess_clock_game_ctrl
// PURPOSE
//  Game sequencer for the two player timer instances of the chess clock.
//  - Debounces the turn lever and the start/pause button.
//  - Decides which timer counts, issues the load of the initial time, and detects flag fall.
//  - Reports winner, move count and game state for the display LEDs.
//  - Sits between the board inputs and both player timers; owns no time arithmetic itself.
// PARAMETERS
//  p_debounce = 1_000_000 : stable cycles required to accept an input change (20 ms @ 50 MHz)
//  p_move_max = 99        : saturation value of the full-move counter
// PORTS
//  i_clk_50m    in   1  system clock, 50 MHz; single clock domain
//  i_rst        in   1  reset, asynchronous, active-high
//  i_sw_turn    in   1  raw turn lever, asynchronous; 0 = A to move, 1 = B to move
//  i_btn_start  in   1  raw start/pause button, asynchronous, active-high
//  i_zero_a     in   1  player A timer has reached 0:00 (level)
//  i_zero_b     in   1  player B timer has reached 0:00 (level)
//  o_load       out  1  1-cycle pulse: both timers load their init value
//  o_run_a      out  1  enable for player A timer countdown
//  o_run_b      out  1  enable for player B timer countdown
//  o_winner     out  2  00 none, 01 A won, 10 B won
//  o_moves      out  7  completed full moves, 0..p_move_max
//  o_state      out  3  current FSM state encoding (for LEDs)
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, debouncers hold 0. Asserting i_rst mid-game aborts it immediately.
//  Input conditioning
//   - Both raw inputs pass a 2-flop synchroniser, then a debouncer.
//   - A debounced level changes only after p_debounce consecutive equal samples.
//   - Debounced lever edge -> "move" event; debounced button rising edge -> "press" event. Each event is 1 cycle.
//  FSM
//   - IDLE  : o_load = 1 for exactly one cycle on entry after reset. Then go to READY.
//   - READY : run enables 0. On press -> RUN_A if lever = 0, RUN_B if lever = 1.
//   - RUN_A : o_run_a = 1. On move -> RUN_B. On press -> PAUSE. On i_zero_a -> OVER, winner = 10.
//   - RUN_B : o_run_b = 1. On move -> RUN_A and o_moves++ (saturating at p_move_max).
//             On press -> PAUSE. On i_zero_b -> OVER, winner = 01.
//   - PAUSE : run enables 0. Lever moves are ignored. On press -> RUN_A or RUN_B chosen by the current lever level.
//   - OVER  : run enables 0, o_winner held. On press -> IDLE, which clears winner and moves and reloads.
//  Latency: an event in cycle n gives a registered state and enable change visible in cycle n+1.
//  Priority within one cycle: flag > press > move.
//  Zero input of the non-running player is ignored.
//  o_run_a and o_run_b are never both 1.
// CONFIGURATION
//  CHESS_CLOCK_INCREMENT_EN
//   - Defined: adds outputs o_inc_a and o_inc_b (1 bit each). A 1-cycle pulse is issued to the player
//     who just completed a move (RUN_A->RUN_B pulses o_inc_a, RUN_B->RUN_A pulses o_inc_b).
//     The pulse coincides with the state change. It is not issued on a flag or when resuming from PAUSE.
//   - Undefined: the ports are absent and no increment logic is generated.
// STRUCTURE
//  chess_clock_pkg
//   - typedef enum logic [2:0] {IDLE, READY, RUN_A, RUN_B, PAUSE, OVER} game_state_t
//   - winner encodings WIN_NONE, WIN_A, WIN_B
//  Sub-module chess_clock_debounce (p_debounce)
//   - Ports: clk, rst, raw in, clean level out, rise and fall pulses out.
//   - Instantiated twice: lever and button.
// TESTING  (p_debounce = 4 in bench)
//  1. Reset, then release -> o_load pulses once, FSM READY, o_run_a = o_run_b = 0.
//  2. Lever 0, press -> o_run_a = 1. Lever to 1 (held 5 cycles) -> o_run_b = 1 one cycle after
//     debounce; lever back to 0 -> o_moves = 1.
//  3. Lever glitch of 2 cycles during RUN_A -> no state change. Press during RUN_B -> PAUSE.
//     Lever toggled in PAUSE -> ignored. Press -> resumes the side given by the lever level.
//  4. RUN_A with i_zero_a = 1 and a lever move in the same cycle -> OVER, winner = 10, no run enable.
//     i_zero_b during RUN_A -> ignored.
//  5. 100 full moves -> o_moves saturates at 99. i_rst asserted mid-RUN_B -> outputs 0 asynchronously.
//  6. With CHESS_CLOCK_INCREMENT_EN: move out of RUN_A -> o_inc_a pulse, 1 cycle.
//     Resume from PAUSE -> no pulse.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types for the chess clock game sequencer: FSM state encoding,
// winner codes and a saturating move-counter helper.
// No logic of its own; imported by the interface and the controller.
package chess_clock_pkg;

   // Encoding is also shown on the state LEDs, so keep the order fixed
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      RUN_A = 3'd2,
      RUN_B = 3'd3,
      PAUSE = 3'd4,
      OVER  = 3'd5
   } game_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;

   // Full-move counter step that sticks at its ceiling
   function automatic logic [6:0] sat_inc(input logic [6:0] value, input logic [6:0] limit);
      return (value >= limit) ? value : value + 7'd1;
   endfunction

endpackage

// File: rtl/chess_clock_game_ctrl_if.sv
// Board/timer side signals of the game sequencer bundled as one interface.
// slave = the sequencer itself; master = whatever drives the board inputs.
// Optional macro CHESS_CLOCK_INCREMENT_EN adds the o_inc_a/o_inc_b pulses.
interface chess_clock_game_ctrl_if;
   import chess_clock_pkg::*;

   logic        i_sw_turn;
   logic        i_btn_start;
   logic        i_zero_a;
   logic        i_zero_b;
   logic        o_load;
   logic        o_run_a;
   logic        o_run_b;
   logic [1:0]  o_winner;
   logic [6:0]  o_moves;
   game_state_t o_state;
`ifdef CHESS_CLOCK_INCREMENT_EN
   logic        o_inc_a;
   logic        o_inc_b;
`endif

   modport slave (
`ifdef CHESS_CLOCK_INCREMENT_EN
      output o_inc_a, o_inc_b,
`endif
      input  i_sw_turn, i_btn_start, i_zero_a, i_zero_b,
      output o_load, o_run_a, o_run_b, o_winner, o_moves, o_state
   );

   modport master (
`ifdef CHESS_CLOCK_INCREMENT_EN
      input  o_inc_a, o_inc_b,
`endif
      output i_sw_turn, i_btn_start, i_zero_a, i_zero_b,
      input  o_load, o_run_a, o_run_b, o_winner, o_moves, o_state
   );

endinterface

// File: rtl/chess_clock_debounce.sv
// Synchronises one raw board input and accepts a new level only after
// p_debounce consecutive samples disagree with the current clean level.
// rise/fall are 1-cycle pulses aligned with the first cycle of the new level.
module chess_clock_debounce #(
   parameter int p_debounce = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int cw = $clog2(p_debounce + 1);

   logic          sync_1;
   logic          sync_2;
   logic [cw-1:0] cnt;

   // Two-flop synchroniser for the asynchronous raw input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Count disagreeing samples; any agreeing sample restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == cw'(p_debounce - 1)) begin
            cnt   <= '0;
            level <= sync_2;
            rise  <= sync_2;
            fall  <= ~sync_2;
         end else begin
            cnt <= cnt + cw'(1);
         end
      end
   end

endmodule

// File: rtl/chess_clock_game_ctrl.sv
// Game sequencer: debounced lever/button drive the turn FSM, timer load and flag fall.
// Latency: an event in cycle n shows as registered state/enable change in cycle n+1.
// Optional macro CHESS_CLOCK_INCREMENT_EN adds per-move increment pulses o_inc_a/o_inc_b.
module chess_clock_game_ctrl
   import chess_clock_pkg::*;
#(
   parameter int p_debounce = 1_000_000,
   parameter int p_move_max = 99
) (
   input logic                   i_clk_50m,
   input logic                   i_rst,
   chess_clock_game_ctrl_if.slave bus
);

   logic        lever_lvl;
   logic        lever_rise;
   logic        lever_fall;
   logic        btn_rise;
   logic        btn_level_unused;
   logic        btn_fall_unused;
   logic        move;
   logic        press;
   logic        live;
   game_state_t state;
   game_state_t next_state;
   logic [1:0]  winner;
   logic [6:0]  moves;

   chess_clock_debounce #(.p_debounce(p_debounce)) u_lever (
      .clk   (i_clk_50m),
      .rst   (i_rst),
      .raw   (bus.i_sw_turn),
      .level (lever_lvl),
      .rise  (lever_rise),
      .fall  (lever_fall)
   );

   chess_clock_debounce #(.p_debounce(p_debounce)) u_button (
      .clk   (i_clk_50m),
      .rst   (i_rst),
      .raw   (bus.i_btn_start),
      .level (btn_level_unused),
      .rise  (btn_rise),
      .fall  (btn_fall_unused)
   );

   // Either lever direction hands the move to the other player
   assign move  = lever_rise | lever_fall;
   assign press = btn_rise;

   // Next state: flag fall beats a press, a press beats a lever move
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (live) next_state = READY;
         READY: if (press) next_state = lever_lvl ? RUN_B : RUN_A;
         RUN_A: begin
            if (bus.i_zero_a)  next_state = OVER;
            else if (press)    next_state = PAUSE;
            else if (move)     next_state = RUN_B;
         end
         RUN_B: begin
            if (bus.i_zero_b)  next_state = OVER;
            else if (press)    next_state = PAUSE;
            else if (move)     next_state = RUN_A;
         end
         PAUSE: if (press) next_state = lever_lvl ? RUN_B : RUN_A;
         OVER:  if (press) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register; live holds IDLE for the reset-release cycle so o_load
   // stays low during reset and pulses exactly once afterwards
   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= next_state;
         live  <= 1'b1;
      end
   end

   // Winner latch and full-move counter, both cleared when a new game starts
   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         winner <= WIN_NONE;
         moves  <= '0;
      end else if (state == OVER && next_state == IDLE) begin
         winner <= WIN_NONE;
         moves  <= '0;
      end else if (state != OVER && next_state == OVER) begin
         winner <= (state == RUN_A) ? WIN_B : WIN_A;
      end else if (state == RUN_B && next_state == RUN_A) begin
         moves <= sat_inc(moves, 7'(p_move_max));
      end
   end

`ifdef CHESS_CLOCK_INCREMENT_EN
   logic inc_a;
   logic inc_b;

   // Bonus time goes to the player who just finished a move, in step with the handover
   always_ff @(posedge i_clk_50m or posedge i_rst) begin
      if (i_rst) begin
         inc_a <= 1'b0;
         inc_b <= 1'b0;
      end else begin
         inc_a <= (state == RUN_A) && (next_state == RUN_B);
         inc_b <= (state == RUN_B) && (next_state == RUN_A);
      end
   end

   assign bus.o_inc_a = inc_a;
   assign bus.o_inc_b = inc_b;
`endif

   assign bus.o_load   = (state == IDLE) && live;
   assign bus.o_run_a  = (state == RUN_A);
   assign bus.o_run_b  = (state == RUN_B);
   assign bus.o_winner = winner;
   assign bus.o_moves  = moves;
   assign bus.o_state  = state;

endmodule

// File: tb/tb_chess_clock_game_ctrl.sv
// Bench for chess_clock_game_ctrl with p_debounce = 4: directed game scenarios,
// then random lever/button/flag activity, all compared every cycle against a
// sample-window reference model; CHESS_CLOCK_INCREMENT_EN adds pulse checks.
module tb_chess_clock_game_ctrl;

   localparam int P        = 4;
   localparam int MOVE_MAX = 99;
   localparam int S_IDLE = 0, S_READY = 1, S_RUN_A = 2, S_RUN_B = 3, S_PAUSE = 4, S_OVER = 5;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   bit   chk_on = 0;

   chess_clock_game_ctrl_if bus();

   chess_clock_game_ctrl #(.p_debounce(P), .p_move_max(MOVE_MAX)) dut (
      .i_clk_50m (clk),
      .i_rst     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Raw input history: h[k] is the raw value seen k clock edges ago.
   bit hl [0:P+1];
   bit hb [0:P+1];
   bit lvl_l, lvl_b, ev_move, ev_press;
   int m_state = S_IDLE, m_win = 0, m_moves = 0, m_age = 0;
   bit m_inc_a, m_inc_b;
   int cnt_inc_a = 0, cnt_inc_b = 0, cnt_load = 0;

   task automatic model_step();
      int ns;
      bit all_l, all_b;
      if (rst) begin
         m_state = S_IDLE; m_win = 0; m_moves = 0; m_age = 0;
         m_inc_a = 0; m_inc_b = 0;
         lvl_l = 0; lvl_b = 0; ev_move = 0; ev_press = 0;
         for (int k = 0; k <= P + 1; k++) begin hl[k] = 0; hb[k] = 0; end
      end else begin
         ns = m_state; m_inc_a = 0; m_inc_b = 0;
         case (m_state)
            S_IDLE: if (m_age >= 1) ns = S_READY;
            S_READY, S_PAUSE: if (ev_press) ns = lvl_l ? S_RUN_B : S_RUN_A;
            S_RUN_A: begin
               if (bus.i_zero_a) begin ns = S_OVER; m_win = 2; end
               else if (ev_press) ns = S_PAUSE;
               else if (ev_move) begin ns = S_RUN_B; m_inc_a = 1; end
            end
            S_RUN_B: begin
               if (bus.i_zero_b) begin ns = S_OVER; m_win = 1; end
               else if (ev_press) ns = S_PAUSE;
               else if (ev_move) begin
                  ns = S_RUN_A; m_inc_b = 1;
                  if (m_moves < MOVE_MAX) m_moves++;
               end
            end
            S_OVER: if (ev_press) begin ns = S_IDLE; m_win = 0; m_moves = 0; end
            default: ;
         endcase
         m_state = ns;
         if (m_age < 2) m_age++;
         // a level flips when the P samples that have cleared the synchroniser all disagree with it
         for (int k = P + 1; k > 0; k--) begin hl[k] = hl[k-1]; hb[k] = hb[k-1]; end
         hl[0] = bus.i_sw_turn;
         hb[0] = bus.i_btn_start;
         all_l = 1; all_b = 1;
         for (int k = 2; k <= P + 1; k++) begin
            if (hl[k] == lvl_l) all_l = 0;
            if (hb[k] == lvl_b) all_b = 0;
         end
         ev_move  = all_l;
         ev_press = all_b && !lvl_b;
         if (all_l) lvl_l = ~lvl_l;
         if (all_b) lvl_b = ~lvl_b;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Compare every output against the model once per cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         chk("state",  int'(bus.o_state), m_state);
         chk("load",   int'(bus.o_load),  int'(m_state == S_IDLE && m_age >= 1));
         chk("run_a",  int'(bus.o_run_a), int'(m_state == S_RUN_A));
         chk("run_b",  int'(bus.o_run_b), int'(m_state == S_RUN_B));
         chk("winner", int'(bus.o_winner), m_win);
         chk("moves",  int'(bus.o_moves), m_moves);
         if (bus.o_load) cnt_load++;
`ifdef CHESS_CLOCK_INCREMENT_EN
         chk("inc_a", int'(bus.o_inc_a), int'(m_inc_a));
         chk("inc_b", int'(bus.o_inc_b), int'(m_inc_b));
         if (bus.o_inc_a) cnt_inc_a++;
         if (bus.o_inc_b) cnt_inc_b++;
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic press();
      bus.i_btn_start = 1'b1; cyc(6);
      bus.i_btn_start = 1'b0; cyc(6);
   endtask

   task automatic lever_set(input logic v);
      bus.i_sw_turn = v; cyc(8);
   endtask

   initial begin
      int snap_a, snap_b, r;
      rst = 1'b1;
      bus.i_sw_turn = 1'b0; bus.i_btn_start = 1'b0;
      bus.i_zero_a = 1'b0;  bus.i_zero_b = 1'b0;
      cyc(3);
      chk_on = 1;
      // 1. reset state, single load pulse, then READY
      chk("rst_state", int'(bus.o_state), 0);
      chk("rst_load",  int'(bus.o_load), 0);
      chk("rst_run",   int'(bus.o_run_a | bus.o_run_b), 0);
      rst = 1'b0;
      cyc(6);
      chk("load_count", cnt_load, 1);
      chk("ready", int'(bus.o_state), S_READY);
      // 2. start with lever 0, hand over, complete one full move
      press();
      chk("start_run_a", int'(bus.o_run_a), 1);
      lever_set(1'b1);
      chk("move_run_b", int'(bus.o_run_b), 1);
      chk("move_run_a_off", int'(bus.o_run_a), 0);
      lever_set(1'b0);
      chk("one_move", int'(bus.o_moves), 1);
      // 3. glitch ignored, pause, lever ignored while paused, resume by lever level
      bus.i_sw_turn = 1'b1; cyc(2); bus.i_sw_turn = 1'b0; cyc(8);
      chk("glitch", int'(bus.o_state), S_RUN_A);
      lever_set(1'b1);
      press();
      chk("pause", int'(bus.o_state), S_PAUSE);
      lever_set(1'b0);
      chk("pause_lever", int'(bus.o_state), S_PAUSE);
      press();
      chk("resume_a", int'(bus.o_state), S_RUN_A);
      // 4. other player's flag ignored; flag and move in the same cycle -> flag wins
      bus.i_zero_b = 1'b1; cyc(3); bus.i_zero_b = 1'b0; cyc(1);
      chk("zero_b_ignored", int'(bus.o_state), S_RUN_A);
      bus.i_sw_turn = 1'b1; cyc(6);
      bus.i_zero_a = 1'b1; cyc(1); bus.i_zero_a = 1'b0;
      chk("over", int'(bus.o_state), S_OVER);
      chk("winner_b", int'(bus.o_winner), 2);
      chk("over_run", int'(bus.o_run_a | bus.o_run_b), 0);
      cyc(4);
      chk("winner_held", int'(bus.o_winner), 2);
      press();
      chk("new_game", int'(bus.o_state), S_READY);
      chk("new_winner", int'(bus.o_winner), 0);
      // 5. saturate the move counter, then abort with an asynchronous reset
      press();
      chk("start_b", int'(bus.o_state), S_RUN_B);
      for (int i = 0; i < 100; i++) begin
         lever_set(1'b0);
         lever_set(1'b1);
      end
      chk("moves_sat", int'(bus.o_moves), 99);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_state", int'(bus.o_state), 0);
      chk("async_run", int'(bus.o_run_a | bus.o_run_b), 0);
      chk("async_moves", int'(bus.o_moves), 0);
      bus.i_sw_turn = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(4);
`ifdef CHESS_CLOCK_INCREMENT_EN
      // 6. pulse on a move out of RUN_A, none when resuming from PAUSE
      press();
      snap_a = cnt_inc_a; snap_b = cnt_inc_b;
      lever_set(1'b1);
      chk("inc_a_pulse", cnt_inc_a - snap_a, 1);
      chk("inc_b_none", cnt_inc_b - snap_b, 0);
      press();
      snap_a = cnt_inc_a; snap_b = cnt_inc_b;
      press();
      chk("resume_no_inc", (cnt_inc_a - snap_a) + (cnt_inc_b - snap_b), 0);
`endif
      // random phase: lever, button, flags and the odd reset
      for (int k = 0; k < 500; k++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: begin bus.i_sw_turn = ~bus.i_sw_turn; cyc($urandom_range(1, 8)); end
            4, 5: begin
               bus.i_btn_start = 1'b1; cyc($urandom_range(1, 8));
               bus.i_btn_start = 1'b0; cyc($urandom_range(1, 8));
            end
            6: begin bus.i_zero_a = 1'b1; cyc($urandom_range(1, 3)); bus.i_zero_a = 1'b0; end
            7: begin bus.i_zero_b = 1'b1; cyc($urandom_range(1, 3)); bus.i_zero_b = 1'b0; end
            8: cyc($urandom_range(1, 10));
            default: begin
               if ($urandom_range(0, 7) == 0) begin rst = 1'b1; cyc(2); rst = 1'b0; end
               else cyc(1);
            end
         endcase
      end
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
